// File: rtl/seq_binary_multiplier.sv
// Sequential shift-add multiplier, unsigned or two's-complement signed.
// Takes B_WIDTH step cycles plus one finalize cycle. The product is held until the next operation completes.
module seq_binary_multiplier #(
   parameter  int A_WIDTH = 3,
   parameter  int B_WIDTH = 4,
   localparam int P_WIDTH = A_WIDTH + B_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               sign_mode,
   input  logic [A_WIDTH-1:0] a,
   input  logic [B_WIDTH-1:0] b,
   output logic [P_WIDTH-1:0] c,
   output logic               busy,
   output logic               done
);

   // state | meaning
   // ------+--------------------------------------------------------------
   // IDLE  | waiting for start; operands are captured on an accepted start
   // CALC  | B_WIDTH shift-add steps, with cnt counting down to 0
   // DONE  | one finalize cycle: c is written, and done pulses on the next cycle
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW = (B_WIDTH > 1) ? $clog2(B_WIDTH) : 1;

   state_t             state, state_nx;
   logic [P_WIDTH-1:0] mcand;
   logic [P_WIDTH-1:0] acc;
   logic [B_WIDTH-1:0] mplier;
   logic [CW-1:0]      cnt;
   logic               neg_flag;
   logic [A_WIDTH-1:0] a_mag;
   logic [B_WIDTH-1:0] b_mag;

   // The most negative value negates onto itself. Read as unsigned, that is the correct magnitude.
   always_comb begin
      a_mag = (sign_mode && a[A_WIDTH-1]) ? -a : a;
      b_mag = (sign_mode && b[B_WIDTH-1]) ? -b : b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CALC;
         CALC:    if (cnt == '0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand    <= '0;
         acc      <= '0;
         mplier   <= '0;
         cnt      <= '0;
         neg_flag <= 1'b0;
         c        <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         busy <= (state == CALC);
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  mcand    <= P_WIDTH'(a_mag);
                  mplier   <= b_mag;
                  acc      <= '0;
                  cnt      <= CW'(B_WIDTH - 1);
                  neg_flag <= sign_mode & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);
               end
            end
            CALC: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CW'(1);
            end
            DONE: begin
               c <= neg_flag ? -acc : acc;
            end
            default: ;
         endcase
      end
   end

endmodule
